// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W            = 5;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned CNT_W_DEF        = 32;

  // addi x0, x0, 0 -- loaded into IF/ID when if_id_flush is set
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  // Pipeline register controls produced each cycle
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET = '{
    pc_write:     1'b0,
    if_id_write:  1'b0,
    if_id_flush:  1'b1,
    id_ex_bubble: 1'b1,
    pipe_freeze:  1'b0
  };

  localparam hz_ctrl_t CTRL_IDLE = '{
    pc_write:     1'b0,
    if_id_write:  1'b0,
    if_id_flush:  1'b0,
    id_ex_bubble: 1'b0,
    pipe_freeze:  1'b0
  };

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline-side view of the hazard controller: hazard sources in, stall/flush controls out.
interface hazard_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_is_halt;
  logic [4:0]       id_ex_rd;
  logic             id_ex_mem_read;
  logic             ex_redirect;
  logic             dmem_ready;
  logic             mem_access;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             is_halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_halt,
           id_ex_rd, id_ex_mem_read, ex_redirect, dmem_ready, mem_access,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           is_halted, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_halt,
           id_ex_rd, id_ex_mem_read, ex_redirect, dmem_ready, mem_access,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           is_halted, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_load_use_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds an operand read in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_mem_read,
  output logic             load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_use_rs1 && (id_rs1 == id_ex_rd);
  assign rs2_hit    = id_use_rs2 && (id_rs2 == id_ex_rd);
  // x0 is hardwired, so a load targeting it never produces a usable value
  assign load_use_c = id_ex_mem_read && (id_ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_control.sv
// ID-stage stall/flush controller: load-use stalls, redirect squashes, dmem freezes, halt drain.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  hazard_control_if.slave  hz
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  logic             load_use;
  logic             mem_wait;

  hz_state_e        state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             flush_inc;
  hz_ctrl_t         ctrl_c;

  load_use_detect u_load_use_detect (
    .id_rs1         (hz.id_rs1),
    .id_rs2         (hz.id_rs2),
    .id_use_rs1     (hz.id_use_rs1),
    .id_use_rs2     (hz.id_use_rs2),
    .id_ex_rd       (hz.id_ex_rd),
    .id_ex_mem_read (hz.id_ex_mem_read),
    .load_use_c     (load_use)
  );

  assign mem_wait = hz.mem_access && !hz.dmem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    halted_d  = halted_q;
    flush_inc = 1'b0;
    ctrl_c    = CTRL_IDLE;

    unique case (state_q)
      RUN: begin
        // Priority order: a frozen MEM stage masks everything; redirect squashes a wrong-path ID
        if (mem_wait) begin
          ctrl_c.pipe_freeze = 1'b1;
        end else if (hz.ex_redirect) begin
          ctrl_c.pc_write     = 1'b1;
          ctrl_c.if_id_flush  = 1'b1;
          ctrl_c.id_ex_bubble = 1'b1;
          flush_inc           = 1'b1;
        end else if (load_use) begin
          ctrl_c.id_ex_bubble = 1'b1;
        end else if (hz.id_is_halt) begin
          ctrl_c.id_ex_bubble = 1'b1;
          state_d             = DRAIN;
          drain_d             = DRAIN_INIT;
        end else begin
          ctrl_c.pc_write    = 1'b1;
          ctrl_c.if_id_write = 1'b1;
        end
      end

      DRAIN: begin
        ctrl_c.id_ex_bubble = 1'b1;
        ctrl_c.pipe_freeze  = mem_wait;
        if (!mem_wait) begin
          if (drain_q == '0) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end

      HALTED: begin
        ctrl_c.id_ex_bubble = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Event counters saturate rather than wrap
    stall_d = stall_q;
    if ((state_q != HALTED) && !ctrl_c.pc_write && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);

    flush_d = flush_q;
    if (flush_inc && (flush_q != '1))
      flush_d = flush_q + CNT_W'(1);

    if (!reset)
      ctrl_c = CTRL_RESET;
  end

  assign hz.pc_write     = ctrl_c.pc_write;
  assign hz.if_id_write  = ctrl_c.if_id_write;
  assign hz.if_id_flush  = ctrl_c.if_id_flush;
  assign hz.id_ex_bubble = ctrl_c.id_ex_bubble;
  assign hz.pipe_freeze  = ctrl_c.pipe_freeze;
  assign hz.is_halted    = halted_q;
  assign hz.stall_count  = stall_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: load-use, x0, redirect, dmem wait, halt drain, async reset.
module tb_hazard_control;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  hazard_control_if #(.CNT_W(32)) hz ();

  hazard_control #(
    .DRAIN_CYCLES (3),
    .CNT_W        (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    hz.id_rs1         = '0;
    hz.id_rs2         = '0;
    hz.id_use_rs1     = 1'b0;
    hz.id_use_rs2     = 1'b0;
    hz.id_is_halt     = 1'b0;
    hz.id_ex_rd       = '0;
    hz.id_ex_mem_read = 1'b0;
    hz.ex_redirect    = 1'b0;
    hz.dmem_ready     = 1'b1;
    hz.mem_access     = 1'b0;
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_forced_reset(input string tag);
    check({tag, "_pc_write"},    32'(hz.pc_write),     32'd0);
    check({tag, "_if_id_write"}, 32'(hz.if_id_write),  32'd0);
    check({tag, "_if_id_flush"}, 32'(hz.if_id_flush),  32'd1);
    check({tag, "_bubble"},      32'(hz.id_ex_bubble), 32'd1);
    check({tag, "_freeze"},      32'(hz.pipe_freeze),  32'd0);
    check({tag, "_halted"},      32'(hz.is_halted),    32'd0);
    check({tag, "_stall_cnt"},   hz.stall_count,       32'd0);
    check({tag, "_flush_cnt"},   hz.flush_count,       32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    idle_inputs();
    #3;
    check_forced_reset("rst");
    tick();
    tick();
    #2 reset = 1'b1;
    settle();
    check("run_idle_pc_write", 32'(hz.pc_write), 32'd1);
    check("run_idle_if_id_write", 32'(hz.if_id_write), 32'd1);
    tick();

    // Load-use: lw x5 in ID/EX, add reading x5 in ID
    hz.id_ex_mem_read = 1'b1;
    hz.id_ex_rd       = 5'd5;
    hz.id_use_rs1     = 1'b1;
    hz.id_rs1         = 5'd5;
    settle();
    check("lu_pc_write", 32'(hz.pc_write), 32'd0);
    check("lu_if_id_write", 32'(hz.if_id_write), 32'd0);
    check("lu_bubble", 32'(hz.id_ex_bubble), 32'd1);
    check("lu_flush", 32'(hz.if_id_flush), 32'd0);
    tick();
    idle_inputs();
    hz.id_use_rs1 = 1'b1;
    hz.id_rs1     = 5'd5;
    settle();
    check("lu_next_pc_write", 32'(hz.pc_write), 32'd1);
    check("lu_stall_cnt", hz.stall_count, 32'd1);
    tick();

    // x0 destination never stalls
    idle_inputs();
    hz.id_ex_mem_read = 1'b1;
    hz.id_ex_rd       = 5'd0;
    hz.id_use_rs1     = 1'b1;
    hz.id_rs1         = 5'd0;
    settle();
    check("x0_pc_write", 32'(hz.pc_write), 32'd1);
    tick();
    // rs2 matches but is not read
    hz.id_ex_rd   = 5'd7;
    hz.id_rs1     = 5'd3;
    hz.id_rs2     = 5'd7;
    hz.id_use_rs2 = 1'b0;
    settle();
    check("unused_rs2_pc_write", 32'(hz.pc_write), 32'd1);
    hz.id_use_rs2 = 1'b1;
    settle();
    check("used_rs2_pc_write", 32'(hz.pc_write), 32'd0);
    hz.id_use_rs2 = 1'b0;
    settle();
    tick();
    check("x0_stall_cnt", hz.stall_count, 32'd1);

    // Redirect beats load-use
    idle_inputs();
    hz.id_ex_mem_read = 1'b1;
    hz.id_ex_rd       = 5'd5;
    hz.id_use_rs1     = 1'b1;
    hz.id_rs1         = 5'd5;
    hz.ex_redirect    = 1'b1;
    settle();
    check("rd_lu_flush", 32'(hz.if_id_flush), 32'd1);
    check("rd_lu_bubble", 32'(hz.id_ex_bubble), 32'd1);
    check("rd_lu_pc_write", 32'(hz.pc_write), 32'd1);
    tick();
    idle_inputs();
    settle();
    check("rd_lu_flush_cnt", hz.flush_count, 32'd1);
    check("rd_lu_stall_cnt", hz.stall_count, 32'd1);

    // dmem wait masks a held redirect for 3 cycles
    hz.mem_access  = 1'b1;
    hz.dmem_ready  = 1'b0;
    hz.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mw%0d_freeze", i), 32'(hz.pipe_freeze), 32'd1);
      check($sformatf("mw%0d_pc_write", i), 32'(hz.pc_write), 32'd0);
      check($sformatf("mw%0d_flush", i), 32'(hz.if_id_flush), 32'd0);
      tick();
    end
    hz.dmem_ready = 1'b1;
    settle();
    check("mw_done_freeze", 32'(hz.pipe_freeze), 32'd0);
    check("mw_done_pc_write", 32'(hz.pc_write), 32'd1);
    check("mw_done_flush", 32'(hz.if_id_flush), 32'd1);
    check("mw_stall_cnt", hz.stall_count, 32'd4);
    tick();
    idle_inputs();
    settle();
    check("mw_flush_cnt", hz.flush_count, 32'd2);

    // Halt: detect, then DRAIN with one frozen cycle -> halted after 5 edges
    hz.id_is_halt = 1'b1;
    settle();
    check("halt_detect_pc_write", 32'(hz.pc_write), 32'd0);
    check("halt_detect_bubble", 32'(hz.id_ex_bubble), 32'd1);
    tick();                                      // edge 1
    idle_inputs();
    hz.ex_redirect = 1'b1;
    settle();
    check("drain_pc_write", 32'(hz.pc_write), 32'd0);
    check("drain_ignores_redirect", 32'(hz.if_id_flush), 32'd0);
    check("drain_halted0", 32'(hz.is_halted), 32'd0);
    tick();                                      // edge 2
    idle_inputs();
    hz.mem_access = 1'b1;
    hz.dmem_ready = 1'b0;
    settle();
    check("drain_freeze", 32'(hz.pipe_freeze), 32'd1);
    tick();                                      // edge 3 (frozen)
    idle_inputs();
    settle();
    check("drain_e3_halted0", 32'(hz.is_halted), 32'd0);
    tick();                                      // edge 4
    check("drain_e4_halted0", 32'(hz.is_halted), 32'd0);
    tick();                                      // edge 5
    check("halt_e5_halted1", 32'(hz.is_halted), 32'd1);
    check("halt_stall_cnt", hz.stall_count, 32'd9);
    check("halt_flush_cnt", hz.flush_count, 32'd2);
    hz.mem_access  = 1'b1;
    hz.dmem_ready  = 1'b0;
    hz.ex_redirect = 1'b1;
    settle();
    check("halted_pc_write", 32'(hz.pc_write), 32'd0);
    check("halted_freeze", 32'(hz.pipe_freeze), 32'd0);
    check("halted_bubble", 32'(hz.id_ex_bubble), 32'd1);
    tick();
    tick();
    check("halted_sticky", 32'(hz.is_halted), 32'd1);
    check("halted_stall_frozen", hz.stall_count, 32'd9);
    check("halted_flush_frozen", hz.flush_count, 32'd2);

    // Async reset out of HALTED, no clock edge needed
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check_forced_reset("rst_halted");
    tick();
    #2 reset = 1'b1;
    settle();
    check("post_rst_pc_write", 32'(hz.pc_write), 32'd1);

    // Async reset mid-DRAIN
    tick();
    hz.id_is_halt = 1'b1;
    settle();
    tick();
    idle_inputs();
    settle();
    check("drain2_pc_write", 32'(hz.pc_write), 32'd0);
    check("drain2_stall_cnt", hz.stall_count, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_forced_reset("rst_drain");
    #1 reset = 1'b1;
    #1;
    check("rst_drain_run_pc_write", 32'(hz.pc_write), 32'd1);
    tick();
    tick();
    tick();
    tick();
    check("resume_halted0", 32'(hz.is_halted), 32'd0);
    check("resume_pc_write", 32'(hz.pc_write), 32'd1);
    check("resume_stall_cnt", hz.stall_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
